// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory initiator.
package lsu_pkg;

  typedef enum logic [1:0] {
    WDT_8  = 2'd0,
    WDT_16 = 2'd1,
    WDT_32 = 2'd2,
    WDT_64 = 2'd3
  } wdt_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitRsp = 2'd2,
    StDone    = 2'd3
  } lsu_state_e;

  // Byte-lane mask of an access before shifting to its offset.
  function automatic logic [7:0] wdt_to_mask(wdt_e wdt);
    logic [7:0] m;
    unique case (wdt)
      WDT_8:  m = 8'h01;
      WDT_16: m = 8'h03;
      WDT_32: m = 8'h0F;
      WDT_64: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Offset bits that are meaningful for an access size; the rest are below the size.
  function automatic logic [2:0] wdt_off_mask(wdt_e wdt);
    logic [2:0] m;
    unique case (wdt)
      WDT_8:  m = 3'b111;
      WDT_16: m = 3'b110;
      WDT_32: m = 3'b100;
      WDT_64: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: load extract/extend, store data shift and write mask.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  input  logic [2:0]  off,
  input  logic [1:0]  wdt,
  input  logic        sext,
  output logic [63:0] rdata_ext,
  output logic [63:0] wdata_sh,
  output logic [7:0]  wmask
);

  logic [63:0] lane;

  // Shift the addressed lane down, extend it; shift store data/mask up.
  always_comb begin
    lane = rdata >> {off, 3'b000};
    unique case (wdt_e'(wdt))
      WDT_8:  rdata_ext = {{56{sext & lane[7]}}, lane[7:0]};
      WDT_16: rdata_ext = {{48{sext & lane[15]}}, lane[15:0]};
      WDT_32: rdata_ext = {{32{sext & lane[31]}}, lane[31:0]};
      WDT_64: rdata_ext = rdata;
    endcase
    wdata_sh = wdata << {off, 3'b000};
    wmask    = wdt_to_mask(wdt_e'(wdt)) << off;
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator between execute and the 64-bit data memory port.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses complete at once with rsp_err=1
// and issue no memory request; otherwise the low offset bits below the size are ignored.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_wdt,
  input  logic        req_sext,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             is_store_q;
  logic [2:0]       off_q;
  logic [1:0]       wdt_q;
  logic             sext_q;

  logic [2:0]  off_in;
  logic        misaligned;
  logic [2:0]  al_off;
  logic [1:0]  al_wdt;
  logic [63:0] al_rdata_ext;
  logic [63:0] al_wdata_sh;
  logic [7:0]  al_wmask;

  assign off_in = req_addr[2:0] & wdt_off_mask(wdt_e'(req_wdt));

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = |(req_addr[2:0] & ~wdt_off_mask(wdt_e'(req_wdt)));
`else
  assign misaligned = 1'b0;
`endif

  // Aligner sees the live request in IDLE (store shift) and the captured one later (load extract).
  assign al_off = (state == StIdle) ? off_in  : off_q;
  assign al_wdt = (state == StIdle) ? req_wdt : wdt_q;

  lsu_lane_align u_align (
    .rdata     (mem_rdata),
    .wdata     (req_wdata),
    .off       (al_off),
    .wdt       (al_wdt),
    .sext      (sext_q),
    .rdata_ext (al_rdata_ext),
    .wdata_sh  (al_wdata_sh),
    .wmask     (al_wmask)
  );

  // FSM with registered handshake and memory outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= StIdle;
      cnt           <= '0;
      is_store_q    <= 1'b0;
      off_q         <= '0;
      wdt_q         <= '0;
      sext_q        <= 1'b0;
      req_ready     <= 1'b1;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (req_valid) begin
            req_ready  <= 1'b0;
            is_store_q <= req_is_store;
            off_q      <= off_in;
            wdt_q      <= req_wdt;
            sext_q     <= req_sext;
            if (misaligned) begin
              state     <= StDone;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state         <= StReq;
              mem_req_valid <= 1'b1;
              mem_addr      <= {req_addr[63:3], 3'b000};
              mem_wen       <= req_is_store;
              mem_wdata     <= req_is_store ? al_wdata_sh : 64'd0;
              mem_wmask     <= req_is_store ? al_wmask : 8'd0;
            end
          end
        end
        StReq: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            cnt           <= '0;
            state         <= StWaitRsp;
          end
        end
        StWaitRsp: begin
          // A response on the final counted cycle still wins over the timeout.
          if (mem_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= is_store_q ? 64'd0 : al_rdata_ext;
            state     <= StDone;
          end else if (cnt == CntLast) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= StDone;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
            state     <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed self-checking bench for lsu_mem_initiator.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_is_store, req_sext;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_wdt;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [63:0] RD = 64'h1122_3344_8055_6677;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_is_store  (req_is_store),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wdt       (req_wdt),
    .req_sext      (req_sext),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns just after the accepting edge.
  task automatic issue(input logic st, input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] wdt, input logic sx);
    req_valid = 1'b1; req_is_store = st; req_addr = addr; req_wdata = wd;
    req_wdt = wdt; req_sext = sx;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 0; req_is_store = 0; req_addr = 0; req_wdata = 0; req_wdt = 0; req_sext = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; rsp_ready = 0;
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset.req_ready got %b want 1", req_ready); end
    n_cmp++; if ({mem_req_valid, mem_wen, rsp_valid, rsp_err} !== 4'b0) begin n_fail++;
      $display("FAIL reset.flags got %b want 0000", {mem_req_valid, mem_wen, rsp_valid, rsp_err}); end
    n_cmp++; if ({mem_addr, mem_wdata, mem_wmask, rsp_rdata} !== '0) begin n_fail++;
      $display("FAIL reset.data got %h/%h/%h/%h want 0", mem_addr, mem_wdata, mem_wmask, rsp_rdata); end
  endtask

  // Full load: accept, ack, respond, check extended data, hand off.
  task automatic test_load(input string name, input logic [63:0] addr, input logic [1:0] wdt,
                           input logic sx, input logic [63:0] exp);
    issue(1'b0, addr, 64'd0, wdt, sx);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_wen !== 1'b0 || req_ready !== 1'b0) begin n_fail++;
      $display("FAIL %s.req got v=%b wen=%b rdy=%b want 1/0/0", name, mem_req_valid, mem_wen, req_ready); end
    n_cmp++; if (mem_addr !== {addr[63:3], 3'b000}) begin n_fail++;
      $display("FAIL %s.mem_addr got %h want %h", name, mem_addr, {addr[63:3], 3'b000}); end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    n_cmp++; if (mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL %s.mem_req_drop got %b want 0", name, mem_req_valid); end
    mem_rsp_valid = 1'b1; mem_rdata = RD; step(); mem_rsp_valid = 1'b0; mem_rdata = 0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== exp) begin n_fail++;
      $display("FAIL %s.rsp got v=%b e=%b d=%h want 1/0/%h", name, rsp_valid, rsp_err, rsp_rdata, exp); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++;
      $display("FAIL %s.handoff got v=%b rdy=%b want 0/1", name, rsp_valid, req_ready); end
  endtask

  task automatic test_store(input string name, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [1:0] wdt, input logic [63:0] exp_wd,
                            input logic [7:0] exp_m);
    issue(1'b1, addr, wd, wdt, 1'b0);
    n_cmp++; if (mem_req_valid !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== {addr[63:3], 3'b000})
    begin n_fail++;
      $display("FAIL %s.req got v=%b wen=%b addr=%h", name, mem_req_valid, mem_wen, mem_addr); end
    n_cmp++; if (mem_wdata !== exp_wd || mem_wmask !== exp_m) begin n_fail++;
      $display("FAIL %s.wdata got %h/%h want %h/%h", name, mem_wdata, mem_wmask, exp_wd, exp_m); end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = RD; step(); mem_rsp_valid = 1'b0; mem_rdata = 0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 64'd0) begin n_fail++;
      $display("FAIL %s.rsp got v=%b e=%b d=%h want 1/0/0", name, rsp_valid, rsp_err, rsp_rdata); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    logic bad;
    issue(1'b0, 64'h1000_0004, 64'd0, 2'd2, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_valid !== 1'b1 || mem_addr !== 64'h1000_0000 || mem_wen !== 1'b0) bad = 1'b1;
      step();
    end
    n_cmp++; if (bad !== 1'b0 || mem_req_valid !== 1'b1 || mem_addr !== 64'h1000_0000) begin
      n_fail++; $display("FAIL stall.mem_hold got v=%b addr=%h want 1/10000000", mem_req_valid, mem_addr); end
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rdata = RD; step(); mem_rsp_valid = 1'b0; mem_rdata = 0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0000_0000_1122_3344 || rsp_err !== 1'b0 ||
          req_ready !== 1'b0) bad = 1'b1;
      step();
    end
    n_cmp++; if (bad !== 1'b0) begin n_fail++;
      $display("FAIL stall.rsp_hold got d=%h v=%b rdy=%b want 1122_3344/1/0", rsp_rdata, rsp_valid, req_ready); end
    rsp_ready = 1'b1; #3;
    n_cmp++; if (req_ready !== 1'b0) begin n_fail++;
      $display("FAIL stall.no_turnaround got %b want 0", req_ready); end
    step(); rsp_ready = 1'b0;
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL stall.release got rdy=%b v=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_timeout();
    int n;
    issue(1'b0, 64'h20, 64'd0, 2'd3, 1'b0);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 400) begin step(); n++; end
    n_cmp++; if (n !== 256) begin n_fail++;
      $display("FAIL timeout.cycles got %0d want 256", n); end
    n_cmp++; if (rsp_err !== 1'b1 || rsp_rdata !== 64'd0) begin n_fail++;
      $display("FAIL timeout.err got e=%b d=%h want 1/0", rsp_err, rsp_rdata); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
    // Stray response in IDLE must be ignored.
    mem_rsp_valid = 1'b1; mem_rdata = RD; step(); mem_rsp_valid = 1'b0;
    step();
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_fail++;
      $display("FAIL stale.ignore got rdy=%b v=%b mv=%b want 1/0/0", req_ready, rsp_valid, mem_req_valid); end
    // Response on the last allowed cycle beats the timeout.
    issue(1'b0, 64'h28, 64'd0, 2'd3, 1'b0);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    for (int i = 0; i < 255; i++) step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++;
      $display("FAIL edge.early got v=%b want 0", rsp_valid); end
    mem_rsp_valid = 1'b1; mem_rdata = RD; step(); mem_rsp_valid = 1'b0; mem_rdata = 0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== RD) begin n_fail++;
      $display("FAIL edge.rsp_wins got v=%b e=%b d=%h want 1/0/%h", rsp_valid, rsp_err, rsp_rdata, RD); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    logic seen;
    seen = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_addr = 64'h8000_0002; req_wdt = 2'd2; req_sext = 1'b0;
    step(); req_valid = 1'b0;
    if (mem_req_valid === 1'b1) seen = 1'b1;
    n_cmp++; if (seen !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 64'd0)
    begin n_fail++;
      $display("FAIL trap got mv=%b v=%b e=%b d=%h want 0/1/1/0", seen, rsp_valid, rsp_err, rsp_rdata); end
    rsp_ready = 1'b1; step(); rsp_ready = 1'b0;
`else
    // Without the trap a 32-bit access at offset 6 reads lane 4.
    test_load("lw_off6", 64'h8000_0006, 2'd2, 1'b1, 64'h0000_0000_1122_3344);
`endif
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 64'h8000_0010, 64'd0, 2'd2, 1'b1);
    mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
    step();
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1 || {mem_req_valid, rsp_valid, rsp_err, mem_wen} !== 4'b0 ||
                 rsp_rdata !== 64'd0 || mem_addr !== 64'd0) begin n_fail++;
      $display("FAIL rst_mid got rdy=%b mv=%b v=%b addr=%h want 1/0/0/0", req_ready, mem_req_valid,
               rsp_valid, mem_addr); end
    step(); rst = 1'b0; step();
    test_load("after_rst", 64'h8000_0001, 2'd0, 1'b0, 64'h66);
  endtask

  initial begin
    test_reset();
    test_load("lb_sx", 64'h8000_0003, 2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FF80);
    test_load("lb_zx", 64'h8000_0003, 2'd0, 1'b0, 64'h80);
    test_load("lh_sx", 64'h8000_0002, 2'd1, 1'b1, 64'hFFFF_FFFF_FFFF_8055);
    test_load("lw_sx", 64'h8000_0004, 2'd2, 1'b1, 64'h0000_0000_1122_3344);
    test_load("ld",    64'h8000_0008, 2'd3, 1'b1, RD);
    test_store("sh", 64'h8000_0006, 64'hBEEF, 2'd1, 64'hBEEF_0000_0000_0000, 8'hC0);
    test_store("sb", 64'h8000_0001, 64'hAB, 2'd0, 64'hAB00, 8'h02);
    test_store("sw", 64'h8000_0004, 64'hDEAD_BEEF, 2'd2, 64'hDEAD_BEEF_0000_0000, 8'hF0);
    test_back_pressure();
    test_timeout();
    test_misalign();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
